// File: rtl/matriz_pkg.sv
// Shared constants and types for the LED matrix scan reader.
// Legacy-compatible state encoding lives here so the bench and the reader agree on it.
package matriz_pkg;

    localparam int unsigned N_COL = 5;
    localparam int unsigned N_LIN = 7;

    typedef logic [1:0]       estado_t;
    typedef logic [2:0]       col_idx_t;
    typedef logic [N_LIN-1:0] linha_t;

    localparam estado_t AGUARDA   = 2'd0;
    localparam estado_t ASSENTA   = 2'd1;
    localparam estado_t CAPTURADO = 2'd2;

    function automatic col_idx_t prox_coluna(input col_idx_t i);
        return (i == col_idx_t'(N_COL - 1)) ? '0 : i + 3'd1;
    endfunction

endpackage

// File: rtl/decodificador_coluna.sv
// Column strobe decoder: classifies the strobes as none, exactly one (with index) or several.
module decodificador_coluna
    import matriz_pkg::*;
#(
    parameter int unsigned COL_ATIVO_BAIXO = 1
)(
    input  logic [N_COL-1:0] c,
    input  logic             valido,
    output logic             nenhuma,
    output logic             unica,
    output logic             multipla,
    output col_idx_t         indice
);

    logic [N_COL-1:0] ativo;
    logic [2:0]       n_ativos;

    // Until the synchronizer has filled after reset its all-zero contents would
    // read as "every column active", so the decode is masked off.
    always_comb begin
        ativo    = (COL_ATIVO_BAIXO != 0) ? ~c : c;
        if (!valido)
            ativo = '0;
        n_ativos = '0;
        indice   = '0;
        for (int unsigned i = 0; i < N_COL; i++) begin
            if (ativo[i]) begin
                n_ativos = n_ativos + 3'd1;
                indice   = col_idx_t'(i);
            end
        end
        nenhuma  = (n_ativos == 3'd0);
        unica    = (n_ativos == 3'd1);
        multipla = (n_ativos > 3'd1);
    end

endmodule

// File: rtl/leitor_matriz_leds.sv
// Snoops a 5x7 multiplexed LED matrix drive and reconstructs complete, settled frames.
module leitor_matriz_leds
    import matriz_pkg::*;
#(
    parameter int unsigned SETTLE          = 4,
    parameter int unsigned TIMEOUT         = 65535,
    parameter int unsigned COL_ATIVO_BAIXO = 1
)(
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [N_LIN-1:0] l,
    input  logic [N_COL-1:0] c,
    input  logic             limpar_erro,
    output logic [N_LIN-1:0] mapa0,
    output logic [N_LIN-1:0] mapa1,
    output logic [N_LIN-1:0] mapa2,
    output logic [N_LIN-1:0] mapa3,
    output logic [N_LIN-1:0] mapa4,
    output logic             frame_valid,
    output logic [7:0]       frame_count,
    output logic             scan_error,
    output logic             sem_sinal
);

    localparam logic [7:0]  CNT_FIM = 8'(SETTLE - 1);
    localparam logic [15:0] T_MAX   = 16'(TIMEOUT);

    logic [N_LIN-1:0] l_s1, l_s2;
    logic [N_COL-1:0] c_s1, c_s2;
    logic [1:0]       sinc_ok;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            l_s1    <= '0;
            l_s2    <= '0;
            c_s1    <= '0;
            c_s2    <= '0;
            sinc_ok <= '0;
        end else begin
            l_s1    <= l;
            l_s2    <= l_s1;
            c_s1    <= c;
            c_s2    <= c_s1;
            sinc_ok <= {sinc_ok[0], 1'b1};
        end
    end

    logic     nenhuma, unica, multipla;
    col_idx_t indice;

    decodificador_coluna #(
        .COL_ATIVO_BAIXO(COL_ATIVO_BAIXO)
    ) u_decodificador (
        .c        (c_s2),
        .valido   (sinc_ok[1]),
        .nenhuma  (nenhuma),
        .unica    (unica),
        .multipla (multipla),
        .indice   (indice)
    );

    estado_t    estado, estado_nx;
    col_idx_t   esp, esp_nx;
    logic [7:0] cnt, cnt_nx;
    logic       captura, violacao;

    always_comb begin
        estado_nx = estado;
        esp_nx    = esp;
        cnt_nx    = cnt;
        captura   = 1'b0;
        violacao  = 1'b0;
        if (!enable) begin
            estado_nx = AGUARDA;
            esp_nx    = '0;
            cnt_nx    = '0;
        end else if (multipla) begin
            violacao  = 1'b1;
            estado_nx = AGUARDA;
            esp_nx    = '0;
            cnt_nx    = '0;
        end else begin
            case (estado)
                AGUARDA: begin
                    esp_nx = '0;
                    if (unica && indice == '0) begin
                        estado_nx = ASSENTA;
                        cnt_nx    = '0;
                    end
                end
                ASSENTA: begin
                    if (unica && indice == esp) begin
                        if (cnt == CNT_FIM) begin
                            captura   = 1'b1;
                            estado_nx = CAPTURADO;
                        end else begin
                            cnt_nx = cnt + 8'd1;
                        end
                    end else begin
                        violacao  = 1'b1;
                        estado_nx = AGUARDA;
                        esp_nx    = '0;
                        cnt_nx    = '0;
                    end
                end
                CAPTURADO: begin
                    if (unica && indice != esp) begin
                        cnt_nx = '0;
                        if (indice == prox_coluna(esp)) begin
                            esp_nx    = indice;
                            estado_nx = ASSENTA;
                        end else begin
                            violacao  = 1'b1;
                            esp_nx    = '0;
                            estado_nx = (indice == '0) ? ASSENTA : AGUARDA;
                        end
                    end
                end
                default: begin
                    estado_nx = AGUARDA;
                    esp_nx    = '0;
                    cnt_nx    = '0;
                end
            endcase
        end
    end

    linha_t      shadow [N_COL];
    linha_t      mapa_r [N_COL];
    logic        commit_pend;
    logic        commit;
    logic [15:0] t_cnt, t_inc;

    assign commit = commit_pend && enable;
    assign t_inc  = (t_cnt == T_MAX) ? t_cnt : t_cnt + 16'd1;

    // Commit runs one cycle behind the last column capture so shadow[4] is already settled.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado      <= AGUARDA;
            esp         <= '0;
            cnt         <= '0;
            commit_pend <= 1'b0;
            frame_valid <= 1'b0;
            frame_count <= '0;
            t_cnt       <= '0;
            sem_sinal   <= 1'b0;
            scan_error  <= 1'b0;
            for (int unsigned i = 0; i < N_COL; i++) begin
                shadow[i] <= '0;
                mapa_r[i] <= '0;
            end
        end else begin
            estado      <= estado_nx;
            esp         <= esp_nx;
            cnt         <= cnt_nx;
            if (captura)
                shadow[esp] <= l_s2;
            commit_pend <= captura && (esp == col_idx_t'(N_COL - 1));
            frame_valid <= commit;
            if (commit) begin
                for (int unsigned i = 0; i < N_COL; i++)
                    mapa_r[i] <= shadow[i];
                frame_count <= frame_count + 8'd1;
                t_cnt       <= '0;
                sem_sinal   <= 1'b0;
            end else if (enable) begin
                t_cnt <= t_inc;
                if (t_inc == T_MAX) begin
                    sem_sinal <= 1'b1;
                    for (int unsigned i = 0; i < N_COL; i++)
                        mapa_r[i] <= '0;
                end
            end
            if (violacao)
                scan_error <= 1'b1;
            else if (limpar_erro)
                scan_error <= 1'b0;
        end
    end

    assign mapa0 = mapa_r[0];
    assign mapa1 = mapa_r[1];
    assign mapa2 = mapa_r[2];
    assign mapa3 = mapa_r[3];
    assign mapa4 = mapa_r[4];

endmodule

// File: tb/tb_leitor_matriz_leds.sv
// Bench for leitor_matriz_leds: directed and random scans checked every cycle
// against a frame-level reference model of the scan protocol.
module tb_leitor_matriz_leds;

    localparam int SET = 4;
    localparam int TMO = 100;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b1;
    logic [6:0] l = '0;
    logic [4:0] c = 5'h1F;
    logic       limpar_erro = 1'b0;
    logic [6:0] mapa0, mapa1, mapa2, mapa3, mapa4;
    logic       frame_valid;
    logic [7:0] frame_count;
    logic       scan_error, sem_sinal;

    leitor_matriz_leds #(
        .SETTLE(SET),
        .TIMEOUT(TMO),
        .COL_ATIVO_BAIXO(1)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .enable      (enable),
        .l           (l),
        .c           (c),
        .limpar_erro (limpar_erro),
        .mapa0       (mapa0),
        .mapa1       (mapa1),
        .mapa2       (mapa2),
        .mapa3       (mapa3),
        .mapa4       (mapa4),
        .frame_valid (frame_valid),
        .frame_count (frame_count),
        .scan_error  (scan_error),
        .sem_sinal   (sem_sinal)
    );

    always #5 clock = ~clock;

    int comparados = 0;
    int falhas     = 0;
    int n_fv       = 0;

    // Reference model: progress through a scan (which column, how many samples seen, captured yet).
    bit         m_em_varredura, m_capturou, m_pend, m_fv, m_err, m_sem;
    int         m_col, m_vistos, m_fc, m_t;
    logic [6:0] m_sh [5];
    logic [6:0] m_mapa [5];
    logic [4:0] h_c [2];
    logic [6:0] h_l [2];
    bit         h_v [2];

    task automatic modelo_reset();
        m_em_varredura = 0; m_capturou = 0; m_pend = 0; m_fv = 0;
        m_err = 0; m_sem = 0; m_col = 0; m_vistos = 0; m_fc = 0; m_t = 0;
        for (int i = 0; i < 5; i++) begin
            m_sh[i] = '0;
            m_mapa[i] = '0;
        end
        for (int i = 0; i < 2; i++) begin
            h_c[i] = '0; h_l[i] = '0; h_v[i] = 0;
        end
    endtask

    task automatic modelo_borda();
        logic [4:0] sc;
        logic [6:0] sl;
        bit sv, err, commit;
        int nact, k;
        sc = h_c[1]; sl = h_l[1]; sv = h_v[1];
        h_c[1] = h_c[0]; h_l[1] = h_l[0]; h_v[1] = h_v[0];
        h_c[0] = c; h_l[0] = l; h_v[0] = 1;
        nact = 0; k = 0;
        for (int i = 0; i < 5; i++)
            if (sv && !sc[i]) begin
                nact++;
                k = i;
            end
        err = 0;
        commit = m_pend && enable;
        m_pend = 0;
        if (!enable) begin
            m_em_varredura = 0;
        end else if (nact > 1) begin
            err = 1;
            m_em_varredura = 0;
        end else if (!m_em_varredura) begin
            if (nact == 1 && k == 0) begin
                m_em_varredura = 1; m_col = 0; m_vistos = 1; m_capturou = 0;
            end
        end else if (!m_capturou) begin
            if (nact == 1 && k == m_col) begin
                m_vistos++;
                if (m_vistos == SET + 1) begin
                    m_sh[m_col] = sl;
                    m_capturou = 1;
                    if (m_col == 4) m_pend = 1;
                end
            end else begin
                err = 1;
                m_em_varredura = 0;
            end
        end else if (nact == 1 && k != m_col) begin
            if (k == (m_col + 1) % 5) begin
                m_col = k; m_vistos = 1; m_capturou = 0;
            end else begin
                err = 1;
                if (k == 0) begin
                    m_col = 0; m_vistos = 1; m_capturou = 0;
                end else begin
                    m_em_varredura = 0;
                end
            end
        end
        m_fv = commit;
        if (commit) begin
            for (int i = 0; i < 5; i++) m_mapa[i] = m_sh[i];
            m_fc = (m_fc + 1) % 256;
            m_t = 0;
            m_sem = 0;
        end else if (enable) begin
            if (m_t < TMO) m_t++;
            if (m_t == TMO) begin
                m_sem = 1;
                for (int i = 0; i < 5; i++) m_mapa[i] = '0;
            end
        end
        if (err) m_err = 1;
        else if (limpar_erro) m_err = 0;
    endtask

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        comparados++;
        assert (obs === esp) else begin
            falhas++;
            $error("FAIL %s: observado=%0h esperado=%0h", tag, obs, esp);
        end
    endtask

    task automatic confere();
        verifica("mapa0", {25'd0, mapa0}, {25'd0, m_mapa[0]});
        verifica("mapa1", {25'd0, mapa1}, {25'd0, m_mapa[1]});
        verifica("mapa2", {25'd0, mapa2}, {25'd0, m_mapa[2]});
        verifica("mapa3", {25'd0, mapa3}, {25'd0, m_mapa[3]});
        verifica("mapa4", {25'd0, mapa4}, {25'd0, m_mapa[4]});
        verifica("frame_valid", {31'd0, frame_valid}, {31'd0, m_fv});
        verifica("frame_count", {24'd0, frame_count}, m_fc);
        verifica("scan_error", {31'd0, scan_error}, {31'd0, m_err});
        verifica("sem_sinal", {31'd0, sem_sinal}, {31'd0, m_sem});
        if (frame_valid === 1'b1) n_fv++;
    endtask

    task automatic passo(input int n);
        repeat (n) begin
            @(posedge clock);
            modelo_borda();
            #1;
            confere();
        end
    endtask

    task automatic coluna(input int k, input logic [6:0] linhas, input int n);
        logic [4:0] um;
        um = 5'b00001 << k;
        c = ~um;
        l = linhas;
        passo(n);
    endtask

    task automatic apaga(input int n);
        c = 5'h1F;
        passo(n);
    endtask

    task automatic varredura(input logic [6:0] r [5], input int hold);
        for (int k = 0; k < 5; k++) coluna(k, r[k], hold);
    endtask

    task automatic limpa_erro();
        limpar_erro = 1'b1;
        passo(1);
        limpar_erro = 1'b0;
    endtask

    task automatic confere_zerado(input string tag);
        verifica({tag, "_mapa"}, {mapa0, mapa1, mapa2, mapa3, mapa4}, 32'd0);
        verifica({tag, "_fv"}, {31'd0, frame_valid}, 32'd0);
        verifica({tag, "_fc"}, {24'd0, frame_count}, 32'd0);
        verifica({tag, "_err"}, {31'd0, scan_error}, 32'd0);
        verifica({tag, "_sem"}, {31'd0, sem_sinal}, 32'd0);
    endtask

    task automatic aplica_reset(input string tag);
        reset_n = 1'b0;
        #1;
        confere_zerado(tag);
        modelo_reset();
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic linhas_aleatorias(output logic [6:0] r [5]);
        for (int k = 0; k < 5; k++) r[k] = 7'($urandom);
    endtask

    logic [6:0] rows [5];
    logic [6:0] salvo [5];
    int fc0, fv0;

    initial begin
        modelo_reset();
        aplica_reset("reset");
        apaga(3);

        // Clean scan, 20 cycles per column
        rows[0] = 7'h01; rows[1] = 7'h02; rows[2] = 7'h04; rows[3] = 7'h08; rows[4] = 7'h10;
        fv0 = n_fv;
        varredura(rows, 20);
        apaga(5);
        verifica("limpa_fv_unico", n_fv - fv0, 1);
        verifica("limpa_mapa", {mapa0, mapa1, mapa2, mapa3, mapa4},
                 {7'h01, 7'h02, 7'h04, 7'h08, 7'h10});
        verifica("limpa_fc", {24'd0, frame_count}, 1);

        // Column 2 held only two cycles
        linhas_aleatorias(rows);
        coluna(0, rows[0], 12); coluna(1, rows[1], 12); coluna(2, rows[2], 2);
        coluna(3, rows[3], 12); coluna(4, rows[4], 12);
        apaga(3);
        verifica("curta_err", {31'd0, scan_error}, 1);
        verifica("curta_fc", {24'd0, frame_count}, 1);
        limpa_erro();
        verifica("limpar_err", {31'd0, scan_error}, 0);
        linhas_aleatorias(rows);
        varredura(rows, 12);
        apaga(3);
        verifica("curta_fc_apos", {24'd0, frame_count}, 2);
        verifica("curta_mapa_apos", {mapa0, mapa1, mapa2, mapa3, mapa4},
                 {rows[0], rows[1], rows[2], rows[3], rows[4]});

        // c0 and c3 together for one cycle mid-scan
        salvo = rows;
        linhas_aleatorias(rows);
        coluna(0, rows[0], 12); coluna(1, rows[1], 12); coluna(2, rows[2], 12);
        c = 5'b10110; passo(1);
        coluna(3, rows[3], 12); coluna(4, rows[4], 12);
        apaga(3);
        verifica("multi_err", {31'd0, scan_error}, 1);
        verifica("multi_mapa", {mapa0, mapa1, mapa2, mapa3, mapa4},
                 {salvo[0], salvo[1], salvo[2], salvo[3], salvo[4]});
        limpa_erro();

        // Order c0,c1,c3 then a proper scan
        coluna(0, 7'h11, 12); coluna(1, 7'h22, 12); coluna(3, 7'h33, 12);
        verifica("ordem_err", {31'd0, scan_error}, 1);
        linhas_aleatorias(rows);
        fc0 = frame_count;
        varredura(rows, 12);
        apaga(3);
        verifica("ordem_fc", {24'd0, frame_count}, fc0 + 1);
        verifica("ordem_mapa", {mapa0, mapa1, mapa2, mapa3, mapa4},
                 {rows[0], rows[1], rows[2], rows[3], rows[4]});
        limpa_erro();

        // Loss of signal
        apaga(TMO + 5);
        verifica("timeout_sem", {31'd0, sem_sinal}, 1);
        verifica("timeout_mapa", {mapa0, mapa1, mapa2, mapa3, mapa4}, 32'd0);
        linhas_aleatorias(rows);
        varredura(rows, 12);
        apaga(3);
        verifica("timeout_recupera", {31'd0, sem_sinal}, 0);

        // Randomized traffic
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 6))
                0: begin
                    linhas_aleatorias(rows);
                    varredura(rows, $urandom_range(5, 14));
                end
                1: begin
                    int curta;
                    curta = $urandom_range(0, 4);
                    linhas_aleatorias(rows);
                    for (int k = 0; k < 5; k++)
                        coluna(k, rows[k], (k == curta) ? $urandom_range(1, 4) : $urandom_range(5, 12));
                end
                2: begin
                    c = 5'(~($urandom_range(3, 31) & 5'h1F) | 5'h00);
                    if ($countones(~c) < 2) c = 5'b11100;
                    passo($urandom_range(1, 3));
                end
                3: apaga($urandom_range(1, 30));
                4: limpa_erro();
                5: begin
                    enable = 1'b0;
                    coluna($urandom_range(0, 4), 7'($urandom), $urandom_range(1, 10));
                    enable = 1'b1;
                end
                default: coluna($urandom_range(0, 4), 7'($urandom), $urandom_range(1, 12));
            endcase
        end
        apaga(3);

        // 256 frames wrap the counter
        fc0 = frame_count;
        for (int f = 0; f < 256; f++) begin
            linhas_aleatorias(rows);
            varredura(rows, 6);
        end
        apaga(3);
        verifica("wrap_fc", {24'd0, frame_count}, fc0);

        // Reset mid-frame, then a partial scan must not commit
        linhas_aleatorias(rows);
        coluna(0, rows[0], 10); coluna(1, rows[1], 10); coluna(2, rows[2], 10);
        coluna(3, rows[3], 3);
        aplica_reset("reset_meio");
        coluna(3, rows[3], 10); coluna(4, rows[4], 10);
        apaga(3);
        verifica("pos_reset_parcial", {24'd0, frame_count}, 0);
        linhas_aleatorias(rows);
        varredura(rows, 10);
        apaga(3);
        verifica("pos_reset_fc", {24'd0, frame_count}, 1);
        verifica("pos_reset_mapa", {mapa0, mapa1, mapa2, mapa3, mapa4},
                 {rows[0], rows[1], rows[2], rows[3], rows[4]});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", comparados, falhas);
        $finish;
    end

endmodule
